spi_flash_responder: RTL and testbench

- Synthesizable SPI serial-flash model: the responder end of the SPI instruction-memory link used by the bus SPI controller.
- Holds a byte-wide memory image and answers the controller's READ transactions over SCLK/CS_N/MOSI/MISO.
- Used as the flash stand-in on FPGA builds and in system benches, so the complete fetch path runs without an external device.
- Runs entirely in the system clock domain and oversamples the SPI pins.

---
 rtl/spi_flash_pkg.sv | 17 +
 rtl/spi_flash_responder_if.sv | 10 +
 rtl/spi_flash_responder_sync_edge.sv | 24 ++
 rtl/spi_flash_responder.sv | 202 ++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, frame constants and FSM states for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_RDID  = 8'h9F;
  localparam int unsigned ADDR_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    IGNORE
  } state_e;

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pin bundle between the bus SPI controller (master) and the flash responder (slave).
interface spi_flash_responder_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_flash_responder_sync_edge.sv
// Two-flop synchronizer with a third flop for rise/fall detection of an async pin.
module spi_sync_edge
  import spi_flash_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= {sr_q[1:0], pin_i};
  end

  assign sync_o = sr_q[1];
  assign rise_o =  sr_q[1] & ~sr_q[2];
  assign fall_o = ~sr_q[1] &  sr_q[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash stand-in: answers READ (0x03) and RDID (0x9F) from a
// backdoor-loaded byte image, oversampling the SPI pins in the clk domain.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned MEM_AW    = 12,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_flash_responder_if.slave  spi,
  input  logic                  load_en,
  input  logic [MEM_AW-1:0]     load_addr,
  input  logic [7:0]            load_data,
  output logic                  busy,
  output logic [7:0]            last_cmd
);

  // Shift register only needs enough history to form a MEM_AW-bit address
  localparam int unsigned SHW = MEM_AW - 1;

  logic [7:0]        mem_q [MEM_DEPTH];

  state_e            state_q,    state_d;
  logic [4:0]        bitcnt_q,   bitcnt_d;
  logic [SHW-1:0]    shift_q,    shift_d;
  logic [MEM_AW-1:0] addr_q,     addr_d;
  logic [7:0]        rd_q,       rd_d;
  logic              fetch_q,    fetch_d;
  logic [1:0]        idbyte_q,   idbyte_d;
  logic              miso_q,     miso_d;
  logic [7:0]        last_cmd_q, last_cmd_d;
  logic              mosi_s1_q,  mosi_s2_q;

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_rise, cs_fall, cs_lvl;
  logic [7:0] opcode;

  spi_sync_edge u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (spi.sclk),
    .sync_o (sclk_lvl_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // Clearing the cs_n flops to 0 means a reset inside a frame sees no fall
  // until cs_n has been high again, so the rest of that frame is ignored.
  spi_sync_edge u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (spi.cs_n),
    .sync_o (cs_lvl),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  assign opcode = {shift_q[6:0], mosi_s2_q};

  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      rd_q       <= '0;
      fetch_q    <= 1'b0;
      idbyte_q   <= '0;
      miso_q     <= 1'b0;
      last_cmd_q <= '0;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      fetch_q    <= fetch_d;
      idbyte_q   <= idbyte_d;
      miso_q     <= miso_d;
      last_cmd_q <= last_cmd_d;
      mosi_s1_q  <= spi.mosi;
      mosi_s2_q  <= mosi_s1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    fetch_d    = 1'b0;
    idbyte_d   = idbyte_q;
    miso_d     = miso_q;
    last_cmd_d = last_cmd_q;

    // Fetch reads the old byte when a backdoor write hits the same address
    if (fetch_q) rd_d = mem_q[addr_q];

    if (state_q != IDLE && (cs_rise || cs_lvl)) begin
      state_d = IDLE;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (cs_fall) begin
            state_d  = CMD;
            bitcnt_d = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            shift_d  = {shift_q[SHW-2:0], mosi_s2_q};
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d   = '0;
              last_cmd_d = opcode;
              if (opcode == CMD_READ) begin
                state_d = ADDR;
              end else if (opcode == CMD_RDID) begin
                state_d  = ID;
                rd_d     = JEDEC_ID[23:16];
                idbyte_d = '0;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            shift_d  = {shift_q[SHW-2:0], mosi_s2_q};
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'(ADDR_BITS - 1)) begin
              bitcnt_d = '0;
              addr_d   = {shift_q, mosi_s2_q};
              fetch_d  = 1'b1;
              state_d  = DATA;
            end
          end
        end
        DATA: begin
          if (sclk_fall) begin
            miso_d   = rd_q[7];
            rd_d     = {rd_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = '0;
              addr_d   = addr_q + MEM_AW'(1);
              fetch_d  = 1'b1;
            end
          end
        end
        ID: begin
          if (sclk_fall) begin
            miso_d   = rd_q[7];
            rd_d     = {rd_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = '0;
              unique case (idbyte_q)
                2'd0: begin
                  rd_d     = JEDEC_ID[15:8];
                  idbyte_d = 2'd1;
                end
                2'd1: begin
                  rd_d     = JEDEC_ID[7:0];
                  idbyte_d = 2'd2;
                end
                default: begin
                  rd_d     = '0;
                  idbyte_d = 2'd3;
                end
              endcase
            end
          end
        end
        IGNORE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  assign spi.miso = miso_q;
  assign busy     = (state_q != IDLE);
  assign last_cmd = last_cmd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI controller tasks feed a byte
// scoreboard; a monitor assembles miso bytes on sclk rise and checks them.
module tb_spi_flash_responder;
  import spi_flash_pkg::*;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [11:0] load_addr;
  logic [7:0]  load_data;
  logic        busy;
  logic [7:0]  last_cmd;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] exp_q [$];
  logic       rx_en = 1'b0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_exp;
  int         rx_n  = 0;

  spi_flash_responder_if spi ();

  spi_flash_responder #(
    .MEM_DEPTH (4096),
    .MEM_AW    (12),
    .JEDEC_ID  (24'hEF4016)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (spi),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy),
    .last_cmd  (last_cmd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: miso is sampled where the controller would, on sclk rise
  always @(posedge spi.sclk) begin
    if (rx_en) begin
      rx_sh = {rx_sh[6:0], spi.miso};
      rx_n++;
      if (rx_n == 8) begin
        rx_n = 0;
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL rx_unexpected: got %0h expected no byte", rx_sh);
        end else begin
          rx_exp = exp_q.pop_front();
          check("rx_byte", {24'h0, rx_sh}, {24'h0, rx_exp});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // Sends the top nb bits of v, MSB first, in SPI mode 0
  task automatic xfer_bits(input logic [7:0] v, input int nb);
    for (int i = 7; i > 7 - nb; i--) begin
      spi.mosi = v[i];
      clks(HALF);
      spi.sclk = 1'b1;
      clks(HALF);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    @(negedge clk);
    spi.cs_n = 1'b0;
    clks(HALF);
  endtask

  task automatic cs_end(input bit chk);
    clks(HALF);
    if (chk) check("busy_before_cs_rise", {31'h0, busy}, 32'd1);
    spi.cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (chk) begin
      check("busy_3clk_after_cs_rise", {31'h0, busy}, 32'd0);
      check("miso_after_cs_rise", {31'h0, spi.miso}, 32'd0);
    end
    clks(6);
  endtask

  task automatic frame(input logic [7:0] op, input logic [23:0] a, input bit has_addr, input int nbytes);
    cs_begin();
    xfer_bits(op, 8);
    if (has_addr) begin
      xfer_bits(a[23:16], 8);
      xfer_bits(a[15:8], 8);
      xfer_bits(a[7:0], 8);
    end
    rx_en = 1'b1;
    for (int b = 0; b < nbytes; b++) xfer_bits(8'h00, 8);
    rx_en = 1'b0;
  endtask

  initial begin
    spi.sclk  = 1'b0;
    spi.cs_n  = 1'b1;
    spi.mosi  = 1'b0;
    rst       = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    clks(4);
    check("reset_busy", {31'h0, busy}, 32'd0);
    check("reset_miso", {31'h0, spi.miso}, 32'd0);
    check("reset_last_cmd", {24'h0, last_cmd}, 32'h00);
    rst = 1'b0;
    clks(4);

    load(12'h000, 8'h13);
    load(12'h001, 8'hA5);
    load(12'h002, 8'h00);
    load(12'h003, 8'hFF);
    load(12'h004, 8'h77);

    // Plain READ from address 0
    exp_q.push_back(8'h13);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    frame(CMD_READ, 24'h000000, 1'b1, 4);
    check("last_cmd_read", {24'h0, last_cmd}, 32'h03);
    cs_end(1'b1);

    // Address wrap from the top of the image
    load(12'hFFF, 8'h5A);
    load(12'h000, 8'hC3);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    frame(CMD_READ, 24'h000FFF, 1'b1, 2);
    cs_end(1'b0);

    // Upper address bits alias
    exp_q.push_back(8'h77);
    frame(CMD_READ, 24'h101004, 1'b1, 1);
    cs_end(1'b0);

    // JEDEC ID then zero fill
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h16);
    exp_q.push_back(8'h00);
    frame(CMD_RDID, 24'h0, 1'b0, 4);
    check("last_cmd_rdid", {24'h0, last_cmd}, 32'h9F);
    cs_end(1'b0);

    // Unknown opcode is ignored
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    frame(8'h05, 24'h0, 1'b0, 2);
    check("last_cmd_unknown", {24'h0, last_cmd}, 32'h05);
    cs_end(1'b1);

    // Partial opcode must not update last_cmd
    cs_begin();
    xfer_bits(8'h9F, 4);
    cs_end(1'b0);
    check("last_cmd_partial_opcode", {24'h0, last_cmd}, 32'h05);

    // Abort after 12 address bits, then a clean READ
    cs_begin();
    xfer_bits(CMD_READ, 8);
    xfer_bits(8'h00, 8);
    xfer_bits(8'h00, 4);
    cs_end(1'b1);
    check("last_cmd_after_abort", {24'h0, last_cmd}, 32'h03);
    exp_q.push_back(8'hA5);
    frame(CMD_READ, 24'h000001, 1'b1, 1);
    cs_end(1'b0);

    // Reset in the middle of DATA, rest of the frame ignored
    exp_q.push_back(8'h00);
    frame(CMD_READ, 24'h000002, 1'b1, 1);
    xfer_bits(8'h00, 3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_data_miso", {31'h0, spi.miso}, 32'd0);
    check("rst_mid_data_busy", {31'h0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xfer_bits(8'hFF, 5);
    clks(4);
    check("post_rst_frame_busy", {31'h0, busy}, 32'd0);
    check("post_rst_frame_miso", {31'h0, spi.miso}, 32'd0);
    cs_end(1'b0);

    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h77);
    frame(CMD_READ, 24'h000003, 1'b1, 2);
    cs_end(1'b1);

    clks(20);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
